// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns 16-bit host frames into
// single-cycle register read/write strobes and returns read data on miso.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);
  typedef enum logic [2:0] {IDLE, CMD, RD_REQ, RD_LOAD, DATA_RD, DATA_WR, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d, sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cmd_done, last_rise, tx_shift;
  logic [4:0] cnt, cnt_nx;
  logic [7:0] sh, sh_nx, tx, tx_nx, data_write_nx;
  logic [5:0] addr_nx;
  logic miso_nx, read_nx, write_nx;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  // cs history resets low so a select held low through reset is not taken as a frame start
  assign cs_fall   = cs_d & ~cs_s;
  assign cmd_done  = rise && cnt == 5'd7;
  assign last_rise = rise && cnt == 5'd15;
  assign tx_shift  = state == DATA_RD && fall && cnt >= 5'd9 && cnt <= 5'd15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:             state_nx = cs_fall ? CMD : IDLE;
      CMD:              state_nx = cs_s ? IDLE : cmd_done ? (sh[6] ? DATA_WR : RD_REQ) : CMD;
      RD_REQ:           state_nx = cs_s ? IDLE : RD_LOAD;
      RD_LOAD:          state_nx = cs_s ? IDLE : DATA_RD;
      DATA_RD, DATA_WR: state_nx = cs_s ? IDLE : last_rise ? DONE : state;
      default:          state_nx = cs_s ? IDLE : DONE;
    endcase
  end

  always_comb begin
    cnt_nx        = (state == IDLE) ? '0 : (rise && state != DONE) ? cnt + 5'd1 : cnt;
    sh_nx         = (state == IDLE) ? '0 : (rise && (state == CMD || state == DATA_WR)) ? {sh[6:0], mosi_s} : sh;
    addr_nx       = (state == CMD && state_nx != CMD && state_nx != IDLE) ? {sh[4:0], mosi_s} : addr;
    read_nx       = state_nx == RD_REQ;
    write_nx      = state == DATA_WR && state_nx == DONE;
    data_write_nx = write_nx ? {sh[6:0], mosi_s} : data_write;
    tx_nx         = (state == RD_LOAD) ? data_read : tx_shift ? {tx[6:0], 1'b0} : tx;
    miso_nx       = (state == RD_LOAD && state_nx == DATA_RD) ? data_read[7] :
                    (state == DATA_RD && state_nx == DATA_RD) ? (tx_shift ? tx[6] : miso) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sh         <= '0;
      tx         <= '0;
      addr       <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      miso       <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      sh         <= sh_nx;
      tx         <= tx_nx;
      addr       <= addr_nx;
      data_write <= data_write_nx;
      read       <= read_nx;
      write      <= write_nx;
      miso       <= miso_nx;
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: host-side SPI driver, register file and scoreboard for spi_reg_bridge.
module tb_spi_reg_bridge;
  localparam int S = 2;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, read, write;
  logic [5:0] addr;
  logic [7:0] data_write, data_read;
  logic [7:0] regs [64];
  logic [7:0] model [64];
  typedef struct {bit wr; logic [5:0] a; logic [7:0] d;} exp_t;
  exp_t exp_q [$];
  exp_t mon_e;
  logic [7:0] exp_miso [$];
  logic [7:0] got_miso [$];
  int n_cmp = 0, n_bad = 0;
  int hp = S + 4;
  logic [7:0] rx;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .read(read), .write(write), .addr(addr), .data_write(data_write), .data_read(data_read)
  );

  always @(posedge clk) begin
    if (!rst_n) regs <= model;
    else begin
      if (write) regs[addr] <= data_write;
      if (read) data_read <= regs[addr];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (read || write)) begin
      check("strobe_exclusive", {31'd0, read & write}, 0);
      if (exp_q.size() == 0) check("unexpected_strobe", {30'd0, read, write}, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind", {31'd0, write}, {31'd0, mon_e.wr});
        check("strobe_addr", {26'd0, addr}, {26'd0, mon_e.a});
        if (mon_e.wr) check("write_data", {24'd0, data_write}, {24'd0, mon_e.d});
      end
    end
  end

  always @(negedge clk) begin
    if (got_miso.size() > 0 && exp_miso.size() > 0)
      check("miso_byte", {24'd0, got_miso.pop_front()}, {24'd0, exp_miso.pop_front()});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                       input bit raise, output logic [7:0] rxb);
    logic [15:0] w;
    w = {b0, b1};
    rxb = '0;
    cs_n = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'($urandom);
      wait_clk(hp);
      sclk = 1'b1;
      if (i >= 8 && i < 16) rxb = {rxb[6:0], miso};
      wait_clk(hp);
      sclk = 1'b0;
    end
    if (raise) begin
      wait_clk(hp);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(S + 4);
    end
  endtask

  // Reference behaviour: a completed write commits, a read strobes once 8 bits arrive,
  // and a read returns the model's current value only when all 16 bits are clocked.
  task automatic op(input bit wr, input bit rsv, input logic [5:0] a, input logic [7:0] d, input int nbits);
    logic [7:0] r;
    if (wr && nbits >= 16) begin
      exp_q.push_back('{1'b1, a, d});
      model[a] = d;
    end
    if (!wr && nbits >= 8) exp_q.push_back('{1'b0, a, 8'd0});
    if (!wr && nbits >= 16) exp_miso.push_back(model[a]);
    frame({wr, rsv, a}, d, nbits, 1'b1, r);
    if (!wr && nbits >= 16) got_miso.push_back(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_miso"}, {31'd0, miso}, 0);
    check({tag, "_read"}, {31'd0, read}, 0);
    check({tag, "_write"}, {31'd0, write}, 0);
    check({tag, "_addr"}, {26'd0, addr}, 0);
    check({tag, "_data_write"}, {24'd0, data_write}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 8'($urandom);
    model[13] = 8'h5A;
    wait_clk(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    wait_clk(5);
    op(1'b1, 1'b0, 6'h00, 8'hAB, 16);
    op(1'b0, 1'b0, 6'h0D, 8'h00, 16);
    op(1'b1, 1'b0, 6'h05, 8'hFF, 12);
    op(1'b1, 1'b0, 6'h05, 8'h3C, 16);
    op(1'b1, 1'b1, 6'h07, 8'h11, 24);
    frame(8'h8A, 8'hFF, 10, 1'b0, rx);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    wait_clk(3);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(S + 4);
    op(1'b0, 1'b0, 6'h0A, 8'h00, 16);
    hp = S + 4;
    op(1'b1, 1'b0, 6'h03, 8'h77, 16);
    op(1'b0, 1'b0, 6'h03, 8'h00, 16);
    for (int k = 0; k < 40; k++) begin
      int r, nb;
      hp = $urandom_range(S + 8, S + 4);
      r = $urandom_range(9, 0);
      nb = (r < 7) ? 16 : (r == 7) ? $urandom_range(15, 1) : $urandom_range(24, 17);
      op(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), nb);
    end
    wait_clk(20);
    check("pending_strobes", exp_q.size(), 0);
    check("pending_miso", exp_miso.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
